// File: rtl/a2d_spi_intf_if.sv
// Signal bundle between the A2D SPI master, its requester and the external A2D.
// The master modport is the SPI master side; slave is the requester/A2D side.
interface a2d_spi_intf_if;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  modport master (
    input  strt_cnv,
    input  chnnl,
    input  MISO,
    output cnv_cmplt,
    output res,
    output SS_n,
    output SCLK,
    output MOSI
  );

  modport slave (
    output strt_cnv,
    output chnnl,
    output MISO,
    input  cnv_cmplt,
    input  res,
    input  SS_n,
    input  SCLK,
    input  MOSI
  );
endinterface

// File: rtl/a2d_spi_intf.sv
// SPI master for an 8-channel 12-bit A2D: one 32-bit frame per strt_cnv, channel
// address sent in both halves, result taken from the last 12 MISO bits.
module a2d_spi_intf #(
  parameter int unsigned SCLK_DIV = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  a2d_spi_intf_if.master      bus_io
);

  localparam int unsigned DivW = $clog2(SCLK_DIV);

  // Divider preset puts the first SCLK fall SCLK_DIV/4 clks after SS_n falls.
  localparam logic [DivW-1:0] DivStart = DivW'(3 * SCLK_DIV / 4);
  localparam logic [DivW-1:0] DivFall  = DivW'(SCLK_DIV - 1);
  localparam logic [DivW-1:0] DivRise  = DivW'(SCLK_DIV / 2 - 1);
  localparam logic [DivW-1:0] DivEnd   = DivW'(3 * SCLK_DIV / 4 - 1);

  typedef enum logic [1:0] {StIdle, StFront, StShift, StBack} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [31:0]       shreg_q, shreg_d;
  logic              ss_n_q, ss_n_d;
  logic              cnv_cmplt_q, cnv_cmplt_d;
  logic [11:0]       res_q, res_d;
  logic              sclk_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      div_q       <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      ss_n_q      <= 1'b1;
      cnv_cmplt_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      ss_n_q      <= ss_n_d;
      cnv_cmplt_q <= cnv_cmplt_d;
      res_q       <= res_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    ss_n_d      = ss_n_q;
    cnv_cmplt_d = cnv_cmplt_q;
    res_d       = res_q;

    sclk_rise = (state_q == StShift) && (div_q == DivRise);

    if (state_q != StIdle) begin
      div_d = div_q + DivW'(1);
    end

    if (sclk_rise) begin
      shreg_d = {shreg_q[30:0], bus_io.MISO};
      // Saturates at 31; only a new accept returns it to 0.
      if (bit_cnt_q != 5'd31) begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus_io.strt_cnv) begin
          state_d     = StFront;
          shreg_d     = {2'b00, bus_io.chnnl, 11'h000, 2'b00, bus_io.chnnl, 11'h000};
          div_d       = DivStart;
          bit_cnt_d   = 5'd0;
          ss_n_d      = 1'b0;
          cnv_cmplt_d = 1'b0;
        end
      end
      StFront: begin
        if (div_q == DivFall) begin
          state_d = StShift;
        end
      end
      StShift: begin
        if (sclk_rise && (bit_cnt_q == 5'd31)) begin
          state_d = StBack;
        end
      end
      StBack: begin
        if (div_q == DivEnd) begin
          state_d     = StIdle;
          ss_n_d      = 1'b1;
          res_d       = shreg_q[11:0];
          cnv_cmplt_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus_io.SS_n      = ss_n_q;
  assign bus_io.SCLK      = ss_n_q | div_q[DivW-1];
  assign bus_io.MOSI      = ~ss_n_q & shreg_q[31];
  assign bus_io.cnv_cmplt = cnv_cmplt_q;
  assign bus_io.res       = res_q;

endmodule

// File: tb/tb_a2d_spi_intf.sv
// Bench for a2d_spi_intf: A2D device model decoding the address from MOSI, plus a
// frame-timing reference model compared against every output on every cycle.
module tb_a2d_spi_intf;

  localparam int Div   = 32;
  localparam int Frame = 32 * Div;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  a2d_spi_intf_if bus ();

  a2d_spi_intf #(
    .SCLK_DIV (Div)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  logic [11:0] chan_val [8];

  // A2D device: learns the channel from MOSI bits 29..27, returns 12 bits on rises 21..32.
  logic        prev_sclk = 1'b1;
  logic        prev_mosi = 1'b0;
  logic [31:0] mosi_rx   = '0;
  logic [2:0]  a2d_addr  = '0;
  int          a2d_cnt   = 0;
  logic        a2d_rise;
  int          cnt_now;

  assign a2d_rise = bus.SCLK & ~prev_sclk;
  assign cnt_now  = a2d_cnt + (a2d_rise ? 1 : 0);

  always @(negedge clk) begin
    prev_sclk <= bus.SCLK;
    prev_mosi <= bus.MOSI;
    if (bus.SS_n) begin
      a2d_cnt  <= 0;
      mosi_rx  <= '0;
      bus.MISO <= 1'($urandom);
    end else begin
      if (a2d_rise) begin
        mosi_rx <= {mosi_rx[30:0], prev_mosi};
        a2d_cnt <= cnt_now;
        if (a2d_cnt == 4) a2d_addr <= {mosi_rx[1:0], prev_mosi};
      end
      if (cnt_now >= 20 && cnt_now < 32) bus.MISO <= chan_val[a2d_addr][31-cnt_now];
      else bus.MISO <= 1'($urandom);
    end
  end

  // SS_n high/low run lengths and cnv_cmplt rise count, in clks.
  logic prev_ss = 1'b1;
  logic prev_cmplt = 1'b0;
  int   high_len = 0, low_len = 0, last_high = 0, last_low = 0, cmplt_rises = 0;

  always @(negedge clk) begin
    prev_ss    <= bus.SS_n;
    prev_cmplt <= bus.cnv_cmplt;
    if (bus.cnv_cmplt && !prev_cmplt) cmplt_rises <= cmplt_rises + 1;
    if (bus.SS_n) begin
      if (!prev_ss) begin
        last_low <= low_len;
        high_len <= 1;
      end else high_len <= high_len + 1;
    end else begin
      if (prev_ss) begin
        last_high <= high_len;
        low_len   <= 1;
      end else low_len <= low_len + 1;
    end
  end

  // Reference model: frame age in clks since accept; outputs derived from timing rules.
  logic        m_active = 1'b0;
  int          m_t      = 0;
  logic [2:0]  m_ch     = '0;
  logic        m_cmplt  = 1'b0;
  logic [11:0] m_res    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_cmplt  <= 1'b0;
      m_res    <= '0;
    end else if (m_active) begin
      m_t <= m_t + 1;
      if (m_t + 1 == Frame) begin
        m_active <= 1'b0;
        m_cmplt  <= 1'b1;
        m_res    <= chan_val[m_ch];
      end
    end else if (bus.strt_cnv) begin
      m_active <= 1'b1;
      m_t      <= 0;
      m_ch     <= bus.chnnl;
      m_cmplt  <= 1'b0;
    end
  end

  function automatic logic exp_sclk(input int t);
    if (t < Div / 4) return 1'b1;
    if (t >= Div / 4 + 31 * Div + Div / 2) return 1'b1;
    return ((t - Div / 4) % Div) >= Div / 2;
  endfunction

  function automatic int exp_rises(input int t);
    int r;
    if (t < Div / 4 + Div / 2) return 0;
    r = (t - Div / 4 - Div / 2) / Div + 1;
    return (r > 32) ? 32 : r;
  endfunction

  function automatic logic exp_mosi(input logic [2:0] ch, input int r);
    logic [31:0] w;
    w = {2'b00, ch, 11'h000, 2'b00, ch, 11'h000};
    return w[31-r];
  endfunction

  always @(negedge clk) begin
    check("SS_n", 32'(bus.SS_n), 32'(!m_active));
    check("SCLK", 32'(bus.SCLK), 32'(m_active ? exp_sclk(m_t) : 1'b1));
    if (!m_active) check("MOSI_idle", 32'(bus.MOSI), 0);
    else if (exp_rises(m_t) < 32)
      check("MOSI", 32'(bus.MOSI), 32'(exp_mosi(m_ch, exp_rises(m_t))));
    check("cnv_cmplt", 32'(bus.cnv_cmplt), 32'(m_cmplt));
    check("res", 32'(bus.res), 32'(m_res));
  end

  // Called #1 after a posedge; returns #1 after the edge that raises cnv_cmplt.
  task automatic do_frame(input logic [2:0] ch, input int inj, output int lat);
    lat = 0;
    bus.strt_cnv = 1'b1;
    bus.chnnl    = ch;
    for (int n = 1; n <= Frame + 64; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        bus.strt_cnv = 1'b0;
        bus.chnnl    = 3'($urandom);
        check("cmplt_clear", 32'(bus.cnv_cmplt), 0);
        check("ss_fall", 32'(bus.SS_n), 0);
      end
      if (n == inj) begin
        bus.strt_cnv = 1'b1;
        bus.chnnl    = 3'd7;
      end else if (n == inj + 1 && n > 1) begin
        bus.strt_cnv = 1'b0;
      end
      if (bus.cnv_cmplt) begin
        lat = n;
        break;
      end
    end
    check("latency", 32'(lat), 32'(Frame + 1));
  endtask

  task automatic new_values();
    for (int i = 0; i < 8; i++) chan_val[i] = {9'($urandom), 3'(i)};
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish, expected finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    int lat;
    int r0;
    logic [2:0] seq [6];
    seq = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
    bus.strt_cnv = 1'b0;
    bus.chnnl    = 3'd0;
    new_values();
    chan_val[4] = 12'hA5C;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset
    repeat (100) @(posedge clk);
    #1;
    check("rst_SS_n", 32'(bus.SS_n), 1);
    check("rst_SCLK", 32'(bus.SCLK), 1);
    check("rst_MOSI", 32'(bus.MOSI), 0);
    check("rst_cmplt", 32'(bus.cnv_cmplt), 0);
    check("rst_res", 32'(bus.res), 0);

    // Channel 4, A2D returns 12'hA5C
    do_frame(3'd4, 0, lat);
    check("res_A5C", 32'(bus.res), 32'h0000_0A5C);
    check("sclk_rises", 32'(a2d_cnt), 32);
    check("mosi_hi", 32'(mosi_rx[31:27]), 32'h4);
    check("mosi_lo", 32'(mosi_rx[15:11]), 32'h4);
    @(negedge clk);
    @(negedge clk);
    check("ss_low_len", 32'(last_low), 1024);

    // strt_cnv mid-frame is ignored
    new_values();
    @(posedge clk);
    #1;
    r0 = cmplt_rises;
    do_frame(3'd2, 300, lat);
    check("ignore_res", 32'(bus.res), 32'(chan_val[2]));
    repeat (40) @(posedge clk);
    #1;
    check("ignore_rises", 32'(cmplt_rises - r0), 1);

    // Back-to-back frames
    do_frame(3'd5, 0, lat);
    check("b2b_res1", 32'(bus.res), 32'(chan_val[5]));
    do_frame(3'd6, 0, lat);
    check("b2b_res2", 32'(bus.res), 32'(chan_val[6]));
    check("b2b_ss_high", 32'(last_high), 1);

    // Reset mid-frame
    bus.strt_cnv = 1'b1;
    bus.chnnl    = 3'd1;
    @(posedge clk);
    #1 bus.strt_cnv = 1'b0;
    repeat (498) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_SS_n", 32'(bus.SS_n), 1);
    check("mid_rst_SCLK", 32'(bus.SCLK), 1);
    check("mid_rst_res", 32'(bus.res), 0);
    check("mid_rst_cmplt", 32'(bus.cnv_cmplt), 0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_frame(3'd3, 0, lat);
    check("post_rst_res", 32'(bus.res), 32'(chan_val[3]));

    // Motion-controller channel sequence
    new_values();
    foreach (seq[i]) begin
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #0;
      do_frame(seq[i], 0, lat);
      check("seq_res", 32'(bus.res), 32'(chan_val[seq[i]]));
    end

    // Random channels and values
    for (int k = 0; k < 4; k++) begin
      logic [2:0] ch;
      new_values();
      ch = 3'($urandom);
      repeat ($urandom_range(1, 30)) @(posedge clk);
      #1;
      do_frame(ch, (k == 1) ? int'($urandom_range(2, 1000)) : 0, lat);
      check("rand_res", 32'(bus.res), 32'(chan_val[ch]));
    end

    repeat (10) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
